gpu_job_scheduler: RTL and testbench

Job scheduler in front of the mini GPU core. It queues filter requests from the microcontroller and launches them one at a time: a held filter type plus a one-cycle start pulse. It then waits for the core's finish pulse, counts filtered-pixel write strobes, and reports each job's completion. A watchdog recovers a hung core by pulsing the core's reset and reporting the job as timed out.

---
 rtl/gpu_job_scheduler.sv | 169 ++++++++++++++++
 tb/tb_gpu_job_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_job_scheduler.sv
// Job scheduler for the mini GPU core: queues filter requests, launches them one at a
// time, counts write strobes per job and recovers a hung core with a watchdog reset.
module gpu_job_scheduler #(
  parameter int unsigned FILTER_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH    = 18,
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned TIMEOUT_WIDTH = 24,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 24'd300000
) (
  input  logic                              i_clk,
  input  logic                              i_nrst,
  input  logic                              i_req_valid,
  input  logic [FILTER_WIDTH-1:0]           i_req_filter,
  output logic                              o_req_ready,
  output logic                              o_gpu_start_pulse,
  output logic [FILTER_WIDTH-1:0]           o_gpu_filter_type,
  output logic                              o_gpu_nrst,
  input  logic                              i_gpu_finish_pulse,
  input  logic                              i_gpu_filtered_wstb,
  output logic                              o_busy,
  output logic                              o_done_pulse,
  output logic [FILTER_WIDTH-1:0]           o_done_filter,
  output logic [ADDR_WIDTH:0]               o_done_count,
  output logic                              o_done_timeout,
  output logic [$clog2(QUEUE_DEPTH):0]      o_queue_level
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST  = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);
  localparam logic [LVL_W-1:0]         LVL_FULL = LVL_W'(QUEUE_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [FILTER_WIDTH-1:0]  mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]         pix_q, pix_d, pix_sat, pix_run;
  logic                     rec_q, rec_d;
  logic                     push, pop;
  logic [LVL_W-1:0]         level_d;

  logic                     start_d, gnrst_d, busy_d, done_d, dto_d, ready_d;
  logic [FILTER_WIDTH-1:0]  ftype_d, dfilt_d;
  logic [CNT_W-1:0]         dcnt_d;

  assign push = i_req_valid && o_req_ready;

  // Next state and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    pix_d   = pix_q;
    rec_d   = rec_q;
    pop     = 1'b0;
    start_d = 1'b0;
    gnrst_d = 1'b1;
    done_d  = 1'b0;
    ftype_d = o_gpu_filter_type;
    dfilt_d = o_done_filter;
    dcnt_d  = o_done_count;
    dto_d   = o_done_timeout;
    pix_sat = (pix_q == {CNT_W{1'b1}}) ? pix_q : pix_q + CNT_W'(1);
    pix_run = i_gpu_filtered_wstb ? pix_sat : pix_q;

    case (state_q)
      S_IDLE: begin
        if (o_queue_level != '0) begin
          pop     = 1'b1;
          ftype_d = mem[rd_ptr];
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        pix_d   = i_gpu_filtered_wstb ? CNT_W'(1) : '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        pix_d = pix_run;
        if (i_gpu_finish_pulse) begin
          done_d  = 1'b1;
          dfilt_d = o_gpu_filter_type;
          dcnt_d  = pix_run;
          dto_d   = 1'b0;
          state_d = S_REPORT;
        end else if (wd_q == WD_LAST) begin
          gnrst_d = 1'b0;
          rec_d   = 1'b0;
          state_d = S_RECOVER;
        end else begin
          wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
      end
      S_RECOVER: begin
        // Core reset is held for two cycles; strobes are not counted here
        if (!rec_q) begin
          rec_d   = 1'b1;
          gnrst_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          dfilt_d = o_gpu_filter_type;
          dcnt_d  = pix_q;
          dto_d   = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    level_d = o_queue_level + LVL_W'(push) - LVL_W'(pop);
    busy_d  = (state_d != S_IDLE);
    ready_d = (level_d != LVL_FULL);
  end

  // State, queue bookkeeping and output registers
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q           <= S_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      wd_q              <= '0;
      pix_q             <= '0;
      rec_q             <= 1'b0;
      o_queue_level     <= '0;
      o_req_ready       <= 1'b1;
      o_gpu_start_pulse <= 1'b0;
      o_gpu_filter_type <= '0;
      o_gpu_nrst        <= 1'b1;
      o_busy            <= 1'b0;
      o_done_pulse      <= 1'b0;
      o_done_filter     <= '0;
      o_done_count      <= '0;
      o_done_timeout    <= 1'b0;
    end else begin
      state_q           <= state_d;
      if (push) wr_ptr  <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr  <= rd_ptr + PTR_W'(1);
      wd_q              <= wd_d;
      pix_q             <= pix_d;
      rec_q             <= rec_d;
      o_queue_level     <= level_d;
      o_req_ready       <= ready_d;
      o_gpu_start_pulse <= start_d;
      o_gpu_filter_type <= ftype_d;
      o_gpu_nrst        <= gnrst_d;
      o_busy            <= busy_d;
      o_done_pulse      <= done_d;
      o_done_filter     <= dfilt_d;
      o_done_count      <= dcnt_d;
      o_done_timeout    <= dto_d;
    end
  end

  // Queue storage needs no reset; pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_req_filter;
  end

endmodule

// File: tb/tb_gpu_job_scheduler.sv
// Directed bench for gpu_job_scheduler: a cycle table for a single job plus
// sequences for queue full, timeout, finish/timeout collision, saturation and reset.
module tb_gpu_job_scheduler;

  logic       clk = 1'b0;
  logic       nrst;
  logic       req_valid;
  logic [1:0] req_filter;
  logic       req_ready;
  logic       start;
  logic [1:0] ftype;
  logic       gnrst;
  logic       fin;
  logic       wstb;
  logic       busy;
  logic       done;
  logic [1:0] dfilt;
  logic [3:0] dcnt;
  logic       dto;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  gpu_job_scheduler #(
    .FILTER_WIDTH(2), .ADDR_WIDTH(3), .QUEUE_DEPTH(4),
    .TIMEOUT_WIDTH(24), .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid), .i_req_filter(req_filter), .o_req_ready(req_ready),
    .o_gpu_start_pulse(start), .o_gpu_filter_type(ftype), .o_gpu_nrst(gnrst),
    .i_gpu_finish_pulse(fin), .i_gpu_filtered_wstb(wstb),
    .o_busy(busy), .o_done_pulse(done), .o_done_filter(dfilt),
    .o_done_count(dcnt), .o_done_timeout(dto), .o_queue_level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic       valid;
    logic [1:0] filt;
    logic       fin;
    logic       wstb;
    logic       e_ready;
    logic       e_start;
    logic [1:0] e_ft;
    logic       e_nrst;
    logic       e_busy;
    logic       e_done;
    logic [1:0] e_df;
    logic [3:0] e_dc;
    logic       e_dto;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mkv(input logic v, input logic [1:0] f, input logic fi,
                               input logic ws, input logic rdy, input logic st,
                               input logic [1:0] ft, input logic nr, input logic bz,
                               input logic dn, input logic [1:0] df,
                               input logic [3:0] dc, input logic dt,
                               input logic [2:0] lv);
    vec_t r;
    r.valid = v;   r.filt = f;    r.fin = fi;   r.wstb = ws;
    r.e_ready = rdy; r.e_start = st; r.e_ft = ft; r.e_nrst = nr;
    r.e_busy = bz; r.e_done = dn; r.e_df = df;  r.e_dc = dc;
    r.e_dto = dt;  r.e_lvl = lv;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic rdy, input logic st,
                           input logic [1:0] ft, input logic nr, input logic bz,
                           input logic dn, input logic [1:0] df, input logic [3:0] dc,
                           input logic dt, input logic [2:0] lv);
    chk({nm, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({nm, ".start"}, 32'(start), 32'(st));
    chk({nm, ".ftype"}, 32'(ftype), 32'(ft));
    chk({nm, ".gpu_nrst"}, 32'(gnrst), 32'(nr));
    chk({nm, ".busy"}, 32'(busy), 32'(bz));
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".done_filter"}, 32'(dfilt), 32'(df));
    chk({nm, ".done_count"}, 32'(dcnt), 32'(dc));
    chk({nm, ".done_timeout"}, 32'(dto), 32'(dt));
    chk({nm, ".level"}, 32'(level), 32'(lv));
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!start && n < 20) begin
      tick();
      n++;
    end
    chk({nm, ".start_seen"}, 32'(start), 32'd1);
  endtask

  // Starts with the LAUNCH cycle visible; strobes on the first nstr cycles, finish after fdel
  task automatic run_job(input string nm, input logic [1:0] f, input int nstr, input int fdel);
    logic held = 1'b1;
    for (int k = 1; k <= fdel; k++) begin
      wstb = (k <= nstr);
      tick();
      if (ftype !== f) held = 1'b0;
    end
    wstb = 1'b0;
    fin  = 1'b1;
    tick();
    fin  = 1'b0;
    chk({nm, ".ftype_held"}, 32'(held), 32'd1);
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".done_filter"}, 32'(dfilt), 32'(f));
    chk({nm, ".done_count"}, 32'(dcnt), 32'(nstr));
    chk({nm, ".done_timeout"}, 32'(dto), 32'd0);
  endtask

  initial begin
    logic ok;
    logic [1:0] order [4];
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;

    // valid filt fin wstb | ready start ft nrst busy done df dc dto lvl
    vecs[0]  = mkv(1, 2, 0, 0,  1, 0, 0, 1, 0, 0,  0, 0, 0, 1);
    vecs[1]  = mkv(0, 0, 0, 0,  1, 1, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 0, 1,  1, 0, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[3]  = mkv(0, 0, 0, 1,  1, 0, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[4]  = mkv(0, 0, 0, 1,  1, 0, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[5]  = mkv(0, 0, 0, 0,  1, 0, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[6]  = mkv(0, 0, 0, 1,  1, 0, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[7]  = mkv(0, 0, 0, 0,  1, 0, 2, 1, 1, 0,  0, 0, 0, 0);
    vecs[8]  = mkv(0, 0, 1, 1,  1, 0, 2, 1, 1, 1,  2, 5, 0, 0);
    vecs[9]  = mkv(0, 0, 0, 0,  1, 0, 2, 1, 0, 0,  2, 5, 0, 0);
    vecs[10] = mkv(0, 0, 1, 1,  1, 0, 2, 1, 0, 0,  2, 5, 0, 0);
    vecs[11] = mkv(0, 0, 1, 1,  1, 0, 2, 1, 0, 0,  2, 5, 0, 0);

    nrst = 1'b0; req_valid = 1'b0; req_filter = 2'd0; fin = 1'b0; wstb = 1'b0;
    tick();
    tick();
    check_all("reset", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    nrst = 1'b1;

    // Single job plus stray finish/strobes while idle
    for (int i = 0; i < 12; i++) begin
      req_valid = vecs[i].valid; req_filter = vecs[i].filt;
      fin = vecs[i].fin; wstb = vecs[i].wstb;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_start, vecs[i].e_ft,
                vecs[i].e_nrst, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_df,
                vecs[i].e_dc, vecs[i].e_dto, vecs[i].e_lvl);
    end
    fin = 1'b0; wstb = 1'b0;
    tick();

    // Queue full: 0 launches, 1,2,3,0 fill the queue, the sixth push is dropped
    req_valid = 1'b1; req_filter = 2'd0; tick();
    chk("qf.level1", 32'(level), 32'd1);
    req_filter = 2'd1; tick();
    chk("qf.start0", 32'(start), 32'd1);
    chk("qf.ftype0", 32'(ftype), 32'd0);
    chk("qf.level_pushpop", 32'(level), 32'd1);
    req_filter = 2'd2; tick();
    req_filter = 2'd3; tick();
    req_filter = 2'd0; tick();
    chk("qf.level4", 32'(level), 32'd4);
    chk("qf.ready_full", 32'(req_ready), 32'd0);
    req_filter = 2'd1; tick();
    chk("qf.level_drop", 32'(level), 32'd4);
    chk("qf.ready_drop", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    fin = 1'b1; tick(); fin = 1'b0;
    chk("qf.job0.done", 32'(done), 32'd1);
    chk("qf.job0.done_filter", 32'(dfilt), 32'd0);
    for (int j = 0; j < 4; j++) begin
      wait_start($sformatf("qf.job%0d", j + 1));
      chk($sformatf("qf.job%0d.ftype", j + 1), 32'(ftype), 32'(order[j]));
      run_job($sformatf("qf.job%0d", j + 1), order[j], j + 1, 4);
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (start) ok = 1'b0;
    end
    chk("qf.no_extra_start", 32'(ok), 32'd1);
    chk("qf.level_empty", 32'(level), 32'd0);

    // Timeout: 16 RUN cycles, 2 cycles of core reset, then timed-out report
    req_valid = 1'b1; req_filter = 2'd3; tick();
    req_filter = 2'd1; tick();
    req_valid = 1'b0;
    chk("to.start", 32'(start), 32'd1);
    chk("to.ftype", 32'(ftype), 32'd3);
    ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wstb = (k <= 3);
      tick();
      if (!gnrst) ok = 1'b0;
    end
    wstb = 1'b0;
    chk("to.nrst_high_in_run", 32'(ok), 32'd1);
    tick();
    chk("to.nrst_low1", 32'(gnrst), 32'd0);
    chk("to.no_done_early", 32'(done), 32'd0);
    wstb = 1'b1; tick();
    chk("to.nrst_low2", 32'(gnrst), 32'd0);
    tick(); wstb = 1'b0;
    chk("to.nrst_release", 32'(gnrst), 32'd1);
    chk("to.done", 32'(done), 32'd1);
    chk("to.done_timeout", 32'(dto), 32'd1);
    chk("to.done_count", 32'(dcnt), 32'd3);
    chk("to.done_filter", 32'(dfilt), 32'd3);
    tick();
    chk("to.idle_busy", 32'(busy), 32'd0);
    tick();
    chk("to.next_start", 32'(start), 32'd1);
    chk("to.next_ftype", 32'(ftype), 32'd1);

    // Finish arriving in the cycle the watchdog reaches its last count
    ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (!gnrst) ok = 1'b0;
    end
    fin = 1'b1; tick(); fin = 1'b0;
    if (!gnrst) ok = 1'b0;
    chk("col.nrst_never_low", 32'(ok), 32'd1);
    chk("col.done", 32'(done), 32'd1);
    chk("col.done_timeout", 32'(dto), 32'd0);
    chk("col.done_filter", 32'(dfilt), 32'd1);
    chk("col.done_count", 32'(dcnt), 32'd0);
    tick();
    chk("col.gpu_nrst_after", 32'(gnrst), 32'd1);

    // Pixel count saturation: 16 strobes into a 4-bit counter
    req_valid = 1'b1; req_filter = 2'd0; tick();
    req_valid = 1'b0; tick();
    chk("sat.start", 32'(start), 32'd1);
    wstb = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    fin = 1'b1; tick(); fin = 1'b0; wstb = 1'b0;
    chk("sat.done", 32'(done), 32'd1);
    chk("sat.done_count", 32'(dcnt), 32'd15);
    chk("sat.done_timeout", 32'(dto), 32'd0);
    tick();

    // Reset mid-RUN with two jobs still queued
    req_valid = 1'b1; req_filter = 2'd1; tick();
    req_filter = 2'd2; tick();
    req_filter = 2'd3; tick();
    req_valid = 1'b0;
    chk("rst.level_before", 32'(level), 32'd2);
    tick();
    nrst = 1'b0; tick(); nrst = 1'b1;
    check_all("rst", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (start || done || busy) ok = 1'b0;
    end
    chk("rst.quiet_after", 32'(ok), 32'd1);
    chk("rst.level_after", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
